if_id_reg: RTL and testbench
============================

// Module: if_id_reg
// PURPOSE
//  IF/ID pipeline register: sits between the fetch stage and the decode stage.
//  - Captures fetched PC and instruction each advancing cycle.
//  - Supports stall (hold) and branch flush (bubble insertion).
//  - Presents a valid bit so decode can ignore bubbles.
// PARAMETERS
//  WIDTH   32             data width of PC and instruction
//  NOP     32'h0000_0000  instruction word presented when the register holds a bubble
//  CNT_W   16             width of statistics counters (used only with IF_ID_STATS_EN)
// PORTS
//  clk             in   1      rising-edge clock
//  rst             in   1      asynchronous reset, active high
//  en              in   1      1 = advance (capture inputs); 0 = stall (hold contents)
//  flush           in   1      1 = squash the instruction being captured (branch taken in ID)
//  PC_in           in   WIDTH  fetch-stage PC of the instruction on instruction_in
//  instruction_in  in   WIDTH  fetch-stage instruction word
//  PC              out  WIDTH  registered PC to decode
//  instruction     out  WIDTH  registered instruction to decode (NOP when valid=0)
//  valid           out  1      1 = instruction is a real fetched instruction
//  stall_cnt       out  CNT_W  cycles with en=0 and flush=0 (IF_ID_STATS_EN only)
//  flush_cnt       out  CNT_W  cycles with flush=1 (IF_ID_STATS_EN only)
// BEHAVIOUR
//  - Reset (rst=1, async): PC=0, instruction=NOP, valid=0, counters=0.
//    Takes effect immediately, regardless of clk, en or flush; outputs stay there while rst=1.
//  - First clk edge after rst deasserts follows the normal rules below.
//  - Latency: 1 cycle; inputs sampled at rising clk edge, visible after that edge.
//  - Priority at each edge, highest first:
//    1. flush=1 (en ignored): PC<=PC_in, instruction<=NOP, valid<=0.
//       A flush during a stall still inserts the bubble.
//    2. en=1: PC<=PC_in, instruction<=instruction_in, valid<=1.
//    3. en=0: PC, instruction and valid hold their previous values exactly.
//  - valid=0 always implies instruction==NOP. The register never outputs a stale
//    instruction with valid=0.
//  - Consecutive flushes: every flushed cycle yields a bubble. No flush state carries
//    over; the next en=1 cycle with flush=0 captures normally.
//  - Stall after flush: the bubble is held (valid stays 0) until the next advance.
//  - No combinational path from any input to any output.
//  - Output state encoding, two states:
//      VALID  : reached by en=1 with flush=0
//      BUBBLE : reached by reset or flush=1
//      en=0 with flush=0 keeps the current state.
// CONFIGURATION
//  - Macro IF_ID_STATS_EN defined:
//    - stall_cnt increments on each edge with en=0, flush=0, rst=0.
//    - flush_cnt increments on each edge with flush=1, rst=0.
//    - Both counters saturate at 2**CNT_W-1 (no wrap) and clear only on rst.
//  - IF_ID_STATS_EN undefined:
//    - No counter flops are synthesised.
//    - stall_cnt and flush_cnt are tied to 0.
//    - Port list is unchanged.
// TESTING
//  1. Reset: assert rst mid-cycle with en=1, valid data on inputs
//     -> PC=0, instruction=NOP, valid=0 before the next clk edge.
//  2. Advance: en=1, flush=0, PC_in=0x10, instruction_in=0x2001_0005, one edge
//     -> PC=0x10, instruction=0x2001_0005, valid=1.
//  3. Stall: after (2), en=0 for 3 edges while inputs change to 0x14 / 0xDEAD_BEEF
//     -> outputs stay 0x10 / 0x2001_0005 / valid=1; stall_cnt=3 (STATS_EN).
//  4. Flush during stall: en=0, flush=1, PC_in=0x18, one edge
//     -> PC=0x18, instruction=NOP, valid=0; flush_cnt=1.
//     Then en=1, flush=0, instruction_in=0x8C22_0004 -> valid=1 with that word.
//  5. Saturation (STATS_EN, CNT_W=4): hold en=0, flush=0 for 20 edges
//     -> stall_cnt=15 after edge 15 and stays 15.
//     Without macro: stall_cnt=0 throughout.

Source files
------------

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall, flush-to-bubble and a valid flag for decode.
// Optional stall/flush statistics counters are enabled with the IF_ID_STATS_EN macro.
module if_id_reg #(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] NOP   = 32'h0000_0000,
   parameter int               CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic [WIDTH-1:0] PC_in,
   input  logic [WIDTH-1:0] instruction_in,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] instruction,
   output logic             valid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [0:0] {
      BUBBLE = 1'b0,
      VALID  = 1'b1
   } state_t;

   state_t           state_r, state_s;
   logic [WIDTH-1:0] pc_r, pc_s;
   logic [WIDTH-1:0] instr_r, instr_s;

   // Next-state: flush beats advance, and a bubble always carries the NOP word
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      instr_s = instr_r;
      if (flush) begin
         state_s = BUBBLE;
         pc_s    = PC_in;
         instr_s = NOP;
      end else if (en) begin
         state_s = VALID;
         pc_s    = PC_in;
         instr_s = instruction_in;
      end else begin
         state_s = state_r;
         pc_s    = pc_r;
         instr_s = instr_r;
      end
   end

   // Pipeline state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= BUBBLE;
         pc_r    <= {WIDTH{1'b0}};
         instr_r <= NOP;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         instr_r <= instr_s;
      end
   end

   assign PC          = pc_r;
   assign instruction = instr_r;
   assign valid       = (state_r == VALID);

`ifdef IF_ID_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;

   // Saturating event counters; a flush edge is never also counted as a stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else if (flush) begin
         if (flush_cnt_r != CNT_MAX) begin
            flush_cnt_r <= flush_cnt_r + CNT_ONE;
         end
      end else if (!en) begin
         if (stall_cnt_r != CNT_MAX) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
         end
      end
   end

   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;
`else
   assign stall_cnt = {CNT_W{1'b0}};
   assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Directed self-checking bench for if_id_reg (non-zero NOP, 4-bit counters).
// Counter expectations follow IF_ID_STATS_EN when the macro is defined.
module tb_if_id_reg;

   localparam int          WIDTH = 32;
   localparam int          CNT_W = 4;
   localparam logic [31:0] NOPW  = 32'h0000_0013;

   logic             clk;
   logic             rst;
   logic             en;
   logic             flush;
   logic [WIDTH-1:0] PC_in;
   logic [WIDTH-1:0] instruction_in;
   logic [WIDTH-1:0] PC;
   logic [WIDTH-1:0] instruction;
   logic             valid;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   int total;
   int bad;

   if_id_reg #(
      .WIDTH (WIDTH),
      .NOP   (NOPW),
      .CNT_W (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .flush          (flush),
      .PC_in          (PC_in),
      .instruction_in (instruction_in),
      .PC             (PC),
      .instruction    (instruction),
      .valid          (valid),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] cnt_exp(input int v);
`ifdef IF_ID_STATS_EN
      return 32'(v);
`else
      return 32'd0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] pc_e, input logic [31:0] ins_e,
                          input logic v_e, input int st_e, input int fl_e);
      chk({tag, ".PC"}, PC, pc_e);
      chk({tag, ".instr"}, instruction, ins_e);
      chk({tag, ".valid"}, 32'(valid), 32'(v_e));
      chk({tag, ".stall_cnt"}, 32'(stall_cnt), cnt_exp(st_e));
      chk({tag, ".flush_cnt"}, 32'(flush_cnt), cnt_exp(fl_e));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      rst            = 1'b1;
      en             = 1'b0;
      flush          = 1'b0;
      PC_in          = 32'h0;
      instruction_in = 32'h0;

      // Power-on reset
      step();
      step();
      chk_all("por", 32'h0, NOPW, 1'b0, 0, 0);

      // Advance
      rst            = 1'b0;
      en             = 1'b1;
      PC_in          = 32'h0000_0010;
      instruction_in = 32'h2001_0005;
      step();
      chk_all("adv", 32'h10, 32'h2001_0005, 1'b1, 0, 0);

      // Stall for three edges with changing inputs
      en             = 1'b0;
      PC_in          = 32'h0000_0014;
      instruction_in = 32'hDEAD_BEEF;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk_all($sformatf("stall%0d", i), 32'h10, 32'h2001_0005, 1'b1, i, 0);
      end

      // Flush during stall inserts a bubble
      flush = 1'b1;
      PC_in = 32'h0000_0018;
      step();
      chk_all("flush_in_stall", 32'h18, NOPW, 1'b0, 3, 1);

      // Bubble is held across a stall
      flush = 1'b0;
      step();
      chk_all("bubble_hold", 32'h18, NOPW, 1'b0, 4, 1);

      // Consecutive flushes, en=1 ignored
      flush          = 1'b1;
      en             = 1'b1;
      PC_in          = 32'h0000_001C;
      instruction_in = 32'h1234_5678;
      step();
      chk_all("flush_a", 32'h1C, NOPW, 1'b0, 4, 2);
      PC_in = 32'h0000_0020;
      step();
      chk_all("flush_b", 32'h20, NOPW, 1'b0, 4, 3);

      // Normal capture resumes after flushes
      flush          = 1'b0;
      PC_in          = 32'h0000_0024;
      instruction_in = 32'h8C22_0004;
      step();
      chk_all("resume", 32'h24, 32'h8C22_0004, 1'b1, 4, 3);

      // Asynchronous reset mid-cycle with en=1 and live inputs
      #2;
      PC_in          = 32'h0000_0028;
      instruction_in = 32'hAAAA_5555;
      rst            = 1'b1;
      #1;
      chk_all("async_rst", 32'h0, NOPW, 1'b0, 0, 0);
      step();
      chk_all("rst_hold", 32'h0, NOPW, 1'b0, 0, 0);

      // Long stall: counter saturates at 15
      rst = 1'b0;
      en  = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step();
         chk($sformatf("sat%0d.stall_cnt", i), 32'(stall_cnt), cnt_exp((i > 15) ? 15 : i));
         chk($sformatf("sat%0d.valid", i), 32'(valid), 32'd0);
      end
      chk("sat.instr", instruction, NOPW);
      chk("sat.flush_cnt", 32'(flush_cnt), cnt_exp(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
